// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: op codes, FSM encoding and op legality check for alu_sched
package alu_sched_pkg;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
  function automatic logic op_legal(input logic [2:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
  endfunction
endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester at or above ptr, with wrap
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    any = |req;
    gnt = any ? {{(N-1){1'b0}}, 1'b1} << idx : '0;
  end
endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin time-sharing of one ALU; ALU_SCHED_OPCHECK_EN adds rsp_err and illegal-op bypass
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int W   = 4,
  parameter int N   = 4,
  parameter int LAT = 1,
  parameter int IW  = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [3*N-1:0] req_op,
  input  logic [W*N-1:0] req_a,
  input  logic [W*N-1:0] req_b,
  input  logic [N-1:0]   req_ci,
  output logic [2:0]     alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_ci,
  input  logic [W-1:0]   alu_y,
  input  logic           alu_co,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IW-1:0]  rsp_id,
  output logic [W-1:0]   rsp_y,
  output logic           rsp_co,
`ifdef ALU_SCHED_OPCHECK_EN
  output logic           rsp_err,
`endif
  output logic           busy
);
  state_t        r_state, w_next;
  logic [IW-1:0] r_ptr, w_idx;
  logic [1:0]    r_cnt;
  logic          r_bubble, w_any, w_xfer, w_bad;
  logic [N-1:0]  w_gnt;
  logic [2:0]    w_op;
  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req(req_valid), .ptr(r_ptr), .gnt(w_gnt), .idx(w_idx), .any(w_any)
  );
  assign w_op = req_op[3*w_idx +: 3];
`ifdef ALU_SCHED_OPCHECK_EN
  assign w_bad = !op_legal(w_op);
`else
  assign w_bad = 1'b0;
`endif
  assign busy = r_state != S_IDLE;
  // r_bubble blocks the first IDLE cycle after a response is accepted
  always_comb begin
    w_xfer    = r_state == S_IDLE && !r_bubble && w_any;
    req_ready = w_xfer ? w_gnt : '0;
    w_next    = w_xfer ? (w_bad ? S_RESP : S_EXEC)
              : (r_state == S_EXEC && r_cnt == '0) ? S_RESP
              : (r_state == S_RESP && rsp_ready) ? S_IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_bubble  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      rsp_co    <= 1'b0;
      alu_op    <= 3'b000;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ci    <= 1'b0;
`ifdef ALU_SCHED_OPCHECK_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      r_state  <= w_next;
      r_bubble <= r_state == S_RESP && rsp_ready;
      if (w_xfer) begin
        r_ptr  <= w_idx == IW'(N - 1) ? '0 : w_idx + 1'b1;
        rsp_id <= w_idx;
`ifdef ALU_SCHED_OPCHECK_EN
        rsp_err <= w_bad;
`endif
        if (w_bad) begin
          rsp_valid <= 1'b1;
          rsp_y     <= '0;
          rsp_co    <= 1'b0;
        end else begin
          alu_op <= w_op;
          alu_a  <= req_a[W*w_idx +: W];
          alu_b  <= req_b[W*w_idx +: W];
          alu_ci <= req_ci[w_idx];
          r_cnt  <= 2'(LAT - 1);
        end
      end
      if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == '0) begin
          rsp_valid <= 1'b1;
          rsp_y     <= alu_y;
          rsp_co    <= alu_co;
        end
      end
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed self-checking bench for alu_sched with a behavioural ALU
module tb_alu_sched;
  localparam int W = 4, N = 4, LAT = 1, IW = 2;
  logic clk = 1'b0, reset_n = 1'b0, rsp_ready = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, req_ci = '0;
  logic [3*N-1:0] req_op = '0;
  logic [W*N-1:0] req_a = '0, req_b = '0;
  logic [2:0] alu_op;
  logic [W-1:0] alu_a, alu_b, alu_y, rsp_y;
  logic alu_ci, alu_co, rsp_valid, rsp_co, busy;
  logic [IW-1:0] rsp_id;
  logic [4:0] sum, dif;
  int checks = 0, errors = 0;
`ifdef ALU_SCHED_OPCHECK_EN
  logic rsp_err;
`endif
  always #5 clk = ~clk;
  alu_sched #(.W(W), .N(N), .LAT(LAT), .IW(IW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_y(alu_y), .alu_co(alu_co), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_co(rsp_co),
`ifdef ALU_SCHED_OPCHECK_EN
    .rsp_err(rsp_err),
`endif
    .busy(busy)
  );
  always_comb begin
    sum    = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_ci);
    dif    = {1'b0, alu_a} - {1'b0, alu_b} - 5'(alu_ci);
    alu_y  = alu_op == 3'b001 ? sum[3:0] : alu_op == 3'b010 ? dif[3:0]
           : alu_op == 3'b100 ? alu_a & alu_b : alu_op == 3'b101 ? alu_a | alu_b
           : alu_op == 3'b110 ? alu_a ^ alu_b : 4'h0;
    alu_co = alu_op == 3'b001 ? sum[4] : alu_op == 3'b010 ? dif[4] : 1'b0;
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int i, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic ci);
    req_op[3*i +: 3] = op;
    req_a[4*i +: 4]  = a;
    req_b[4*i +: 4]  = b;
    req_ci[i]        = ci;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_rsp_y", 32'(rsp_y), 0);
    reset_n = 1'b1;
    tick();
    set_req(0, 3'b001, 4'd3, 4'd2, 1'b0);
    req_valid = 4'b0001;
    #1 chk("t1_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_exec_ready", 32'(req_ready), 0);
    chk("t1_exec_valid", 32'(rsp_valid), 0);
    chk("t1_alu_a", 32'(alu_a), 3);
    tick();
    chk("t1_valid", 32'(rsp_valid), 1);
    chk("t1_id", 32'(rsp_id), 0);
    chk("t1_y", 32'(rsp_y), 5);
    chk("t1_co", 32'(rsp_co), 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1_done", 32'(rsp_valid), 0);
    set_req(2, 3'b001, 4'd15, 4'd1, 1'b0);
    req_valid = 4'b0100;
    #1 chk("t2_bubble", 32'(req_ready), 0);
    tick();
    chk("t2_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    tick();
    chk("t2_id", 32'(rsp_id), 2);
    chk("t2_y", 32'(rsp_y), 0);
    chk("t2_co", 32'(rsp_co), 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 3'b001, 4'(i + 4), 4'd0, 1'b0);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1 chk($sformatf("rr_ready_c%0d", c), 32'(req_ready),
             c % 4 == 0 ? 32'(1) << ((c / 4) % 4) : 32'd0);
      if (c % 4 == 2) begin
        chk($sformatf("rr_valid_c%0d", c), 32'(rsp_valid), 1);
        chk($sformatf("rr_id_c%0d", c), 32'(rsp_id), (c / 4) % 4);
        chk($sformatf("rr_y_c%0d", c), 32'(rsp_y), (c / 4) % 4 + 4);
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    set_req(1, 3'b010, 4'd1, 4'd3, 1'b0);
    req_valid = 4'b0010;
    #1 chk("bp_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1111;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_y", 32'(rsp_y), 14);
      chk("bp_co", 32'(rsp_co), 1);
      chk("bp_req_ready", 32'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("bp_hold", 32'(rsp_valid), 1);
    tick();
    rsp_ready = 1'b0;
    chk("bp_accept", 32'(rsp_valid), 0);
    chk("bp_bubble", 32'(req_ready), 0);
    req_valid = '0;
    tick();
    set_req(2, 3'b100, 4'd6, 4'd3, 1'b0);
    req_valid = 4'b0100;
    #1 chk("rx_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rx_valid", 32'(rsp_valid), 0);
    chk("rx_busy", 32'(busy), 0);
    chk("rx_alu_op", 32'(alu_op), 0);
    chk("rx_alu_a", 32'(alu_a), 0);
    chk("rx_id", 32'(rsp_id), 0);
    tick();
    chk("rx_no_rsp", 32'(rsp_valid), 0);
    set_req(0, 3'b001, 4'd3, 4'd2, 1'b0);
    set_req(3, 3'b001, 4'd1, 4'd1, 1'b0);
    req_valid = 4'b1101;
    #1 chk("rx_ptr0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    chk("rx_y", 32'(rsp_y), 5);
`ifdef ALU_SCHED_OPCHECK_EN
    chk("rx_err", 32'(rsp_err), 0);
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
`ifdef ALU_SCHED_OPCHECK_EN
    set_req(0, 3'b111, 4'd9, 4'd9, 1'b1);
    req_valid = 4'b0001;
    #1 chk("oc_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    chk("oc_valid", 32'(rsp_valid), 1);
    chk("oc_err", 32'(rsp_err), 1);
    chk("oc_y", 32'(rsp_y), 0);
    chk("oc_alu_op", 32'(alu_op), 32'b001);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Time-shares one alu_v2 instance between N requesters.
- Round-robin arbitration over valid/ready request channels; drives the ALU operands, waits a fixed latency, captures the result, and returns it on a single tagged response channel.
- Sits between the instruction/fetch units and the shared ALU; the ALU itself is instantiated outside this block.

Parameters:
- W, 4, operand/result width in bits (matches alu_v2 W).
- N, 4, number of requesters (2..8).
- LAT, 1, ALU result latency in cycles from operand drive to sample (1..4).
- IW, $clog2(N), width of the requester ID.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous reset, active low.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  per-requester accept; one-hot or zero.
- req_op  in  3*N  op per requester; slice i = [3i+2:3i].
- req_a  in  W*N  operand A per requester.
- req_b  in  W*N  operand B per requester.
- req_ci  in  N  carry-in per requester.
- alu_op  out  3  to ALU op.
- alu_a  out  W  to ALU a.
- alu_b  out  W  to ALU b.
- alu_ci  out  1  to ALU ci.
- alu_y  in  W  ALU result.
- alu_co  in  1  ALU carry/borrow out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IW  ID of the requester that owns the response.
- rsp_y  out  W  captured result.
- rsp_co  out  1  captured carry.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on reset_n, sampled on the clk rising edge.
- Reset values: FSM=IDLE, rr pointer=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_co=0, alu_op=3'b000, alu_a=0, alu_b=0, alu_ci=0, busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = first i with req_valid[i]=1, scanning from rr pointer upward with wrap-around.
  - req_ready[grant] asserted combinationally in the same cycle; a transfer occurs when valid&&ready.
  - On transfer: latch op/a/b/ci and the ID into the alu_* and id registers; load wait counter = LAT-1; go to EXEC.
  - rr pointer = grant+1 mod N.
  - No valid requests: stay in IDLE, req_ready=0.
- EXEC:
  - alu_* held stable; req_ready=0.
  - Counter decrements each cycle.
  - At 0: capture alu_y/alu_co into rsp_y/rsp_co, set rsp_valid=1, go to RESP.
  - Latency from request transfer to rsp_valid = LAT+1 cycles.
- RESP:
  - Hold rsp_* until rsp_valid&&rsp_ready.
  - Then rsp_valid=0 and go to IDLE. No new grant in that cycle (one-cycle bubble).
- alu_* outputs keep their last values in IDLE (no toggling).
- At most one transaction in flight. req_ready is never asserted outside IDLE.
- Requester rules:
  - A requester must hold req_* stable while valid and not ready.
  - Deasserting valid before grant is permitted.
- Arithmetic: the block does not compute. W-bit values pass through unchanged. rsp_co is the ALU carry for add and the borrow for sub, and is don't-care for logic ops.
- Simultaneous requests: resolved by the rr pointer only. A requester that just won is lowest priority next.
- Reset mid-operation: an in-flight transaction is discarded and no response is produced.
- N not a power of two: the pointer wraps at N-1, not at 2^IW-1.

Optional Feature:
- Macro: ALU_SCHED_OPCHECK_EN.
- When defined:
  - Adds output rsp_err (1 bit, reset 0).
  - A granted request whose op is not in {ADD, SUB, AND, OR, XOR} skips EXEC and goes directly to RESP.
  - In that case rsp_y=0, rsp_co=0, rsp_err=1, and alu_* are not updated.
  - Latency is 1 cycle.
  - rsp_err=0 for legal ops.
- When not defined: no rsp_err port. Every op is forwarded to the ALU unchecked.

Decomposition:
- Package alu_sched_pkg:
  - Op constants OP_ADD=3'b001, OP_SUB=3'b010, OP_AND=3'b100, OP_OR=3'b101, OP_XOR=3'b110.
  - FSM state encoding.
  - Function op_legal(op).
- Sub-module rr_arbiter (params N; inputs req, ptr; output one-hot grant plus grant index) handles arbitration.
- FSM and datapath registers stay in alu_sched.

Test Plan:
- Setup for all tests: W=4, N=4, LAT=1.
- Single request: req_valid=4'b0001, op=ADD, a=3, b=2, ci=0 → req_ready[0] the same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_y=5, rsp_co=0.
- Wrap and carry: requester 2, op=ADD, a=15, b=1 → rsp_y=0, rsp_co=1.
- Round robin: all four valid continuously, rsp_ready=1 → grant order 0,1,2,3,0; a new grant every 4 cycles.
- Backpressure: requester 1, op=SUB, a=1, b=3; rsp_ready held low 5 cycles → rsp_y=14 and rsp_co stable throughout; req_ready stays 0; accept occurs on the cycle rsp_ready=1.
- Reset in EXEC: reset_n=0 for 1 cycle after a grant → no rsp_valid; all outputs at reset values; next grant comes from requester 0.
- With ALU_SCHED_OPCHECK_EN, op=3'b111 → rsp_valid the next cycle with rsp_err=1, rsp_y=0, alu_op unchanged.
